// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared encodings and helpers for the AHB round-robin arbiter.
//   - htrans_e    : AHB HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   - hburst_e    : AHB HBURST encodings (SINGLE .. INCR16)
//   - arb_state_e : arbiter states (PARK, BUS, BURST, LOCKED)
//   - burst_beats : number of beats of a burst type (1 for SINGLE/INCR)
// ----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_BUS    = 2'd1,
        ST_BURST  = 2'd2,
        ST_LOCKED = 2'd3
    } arb_state_e;

    // Beat counter holds beats-1 of the longest fixed burst (16 -> 15).
    localparam int BEAT_W = 4;

    // Beats of a burst; undefined-length INCR counts as 1 since it is never
    // protected by the beat counter.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                      beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req_i starting at (ptr_i+1)
// modulo NUM_MST, wrapping, and returns the first requester as a one-hot
// vector. ptr_i itself is searched last, so the current owner only wins
// when nobody else requests.
// Ports:
//   req_i   [NUM_MST] : request vector
//   ptr_i   [MW]      : index of the last owner
//   gnt_o   [NUM_MST] : one-hot winner (all zero when no request)
//   valid_o           : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_MST = 4,
    localparam int MW      = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [MW-1:0]      ptr_i,
    output logic [NUM_MST-1:0] gnt_o,
    output logic               valid_o
);

    // Rotating priority search; the first hit blocks all later candidates.
    always_comb begin
        logic [MW-1:0] idx_s;
        logic          hit_s;
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int i = 1; i <= NUM_MST; i++) begin
            idx_s        = MW'((int'(ptr_i) + i) % NUM_MST);
            hit_s        = !valid_o && req_i[idx_s];
            gnt_o[idx_s] = gnt_o[idx_s] | hit_s;
            valid_o      = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_arbiter
// Round-robin AHB-Lite bus arbiter for NUM_MST masters. Fixed-length bursts
// and locked sequences are never split; the bus parks on DEF_MST when idle.
// Optional feature macro: AHB_ARB_TIMEOUT_EN (forces re-arbitration after
// TIMEOUT idle cycles of an owner that keeps requesting while others wait).
// Ports:
//   clk, rst (async, active high)
//   req_i  [NUM_MST] : bus requests          lock_i [NUM_MST] : lock requests
//   htrans_i [2]     : HTRANS of granted master
//   hburst_i [3]     : HBURST of granted master
//   hready_i         : bus HREADY
//   grant_o [NUM_MST]: registered one-hot grant
//   hmaster_o [MW]   : owner of the current address phase
//   hmastlock_o      : current address phase is locked
// ----------------------------------------------------------------------------
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MST = 4,
    parameter  int DEF_MST = 0,
    parameter  int TIMEOUT = 16,
    localparam int MW      = $clog2(NUM_MST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MST-1:0] req_i,
    input  logic [NUM_MST-1:0] lock_i,
    input  logic [1:0]         htrans_i,
    input  logic [2:0]         hburst_i,
    input  logic               hready_i,
    output logic [NUM_MST-1:0] grant_o,
    output logic [MW-1:0]      hmaster_o,
    output logic               hmastlock_o
);

    localparam logic [NUM_MST-1:0] DEF_OH  = NUM_MST'(1) << DEF_MST;
    localparam logic [MW-1:0]      DEF_IDX = MW'(DEF_MST);

    function automatic logic [MW-1:0] onehot_to_idx(input logic [NUM_MST-1:0] oh);
        logic [MW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            idx = idx | (oh[i] ? MW'(i) : MW'(0));
        end
        return idx;
    endfunction

    arb_state_e          state_q, state_d, fsm_state_s;
    logic [NUM_MST-1:0]  grant_q, grant_d;
    logic [MW-1:0]       ptr_q, ptr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d, fsm_beat_s, trk_cnt_s;
    logic [MW-1:0]       hmaster_q;
    logic                hmastlock_q;

    logic [NUM_MST-1:0]  pick_gnt_s;
    logic                pick_valid_s;
    logic                rearb_s;
    logic                timeout_hit_s;
    logic [MW-1:0]       grant_idx_s;
    logic                own_req_s;
    logic                own_lock_s;
    logic [4:0]          beats_s;
    logic                fixed_burst_s;
    logic [BEAT_W-1:0]   beat_load_s;

    // ptr_q is the last real owner; outside PARK it is the current owner.
    assign own_req_s     = req_i[ptr_q];
    assign own_lock_s    = lock_i[ptr_q];
    assign grant_idx_s   = onehot_to_idx(grant_q);
    assign beats_s       = burst_beats(hburst_i);
    assign fixed_burst_s = (beats_s != 5'd1);
    assign beat_load_s   = BEAT_W'(beats_s - 5'd1);

    rr_pick #(
        .NUM_MST (NUM_MST)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_s),
        .valid_o (pick_valid_s)
    );

    // Beat counter value after an accepted transfer; this tracking runs in
    // every owned state so a burst started under lock is still protected.
    always_comb begin
        trk_cnt_s = beat_cnt_q;
        case (htrans_i)
            HTRANS_SEQ:    trk_cnt_s = (beat_cnt_q != 4'd0) ? (beat_cnt_q - 4'd1) : 4'd0;
            HTRANS_BUSY:   trk_cnt_s = beat_cnt_q;
            HTRANS_NONSEQ: trk_cnt_s = fixed_burst_s ? beat_load_s : 4'd0;
            HTRANS_IDLE:   trk_cnt_s = 4'd0;
            default:       trk_cnt_s = 4'd0;
        endcase
    end

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_qual_s;

    // Owner idles on the bus while holding it and someone else is waiting.
    assign to_qual_s     = (state_q == ST_BUS) && (htrans_i == HTRANS_IDLE)
                           && own_req_s && (|(req_i & ~grant_q));
    assign timeout_hit_s = hready_i && to_qual_s && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Idle-owner counter: counts qualifying accepted cycles, clears otherwise.
    always_comb begin
        if (!hready_i) begin
            to_cnt_d = to_cnt_q;
        end else if (!to_qual_s || timeout_hit_s) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Idle-owner counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_hit_s    = 1'b0;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    // FSM next state: decides whether this accepted cycle may re-arbitrate.
    always_comb begin
        fsm_state_s = state_q;
        fsm_beat_s  = beat_cnt_q;
        rearb_s     = 1'b0;
        if (hready_i) begin
            case (state_q)
                ST_PARK: begin
                    rearb_s = pick_valid_s;
                end
                ST_BUS, ST_BURST, ST_LOCKED: begin
                    fsm_beat_s = trk_cnt_s;
                    if (own_lock_s) begin
                        // Lock wins over a simultaneous burst start.
                        fsm_state_s = ST_LOCKED;
                    end else if (trk_cnt_s != 4'd0) begin
                        fsm_state_s = ST_BURST;
                    end else if ((state_q == ST_BURST) && (htrans_i == HTRANS_SEQ)) begin
                        // Last beat accepted: everyone may compete again.
                        rearb_s = 1'b1;
                    end else if (!own_req_s || timeout_hit_s) begin
                        rearb_s = 1'b1;
                    end else begin
                        fsm_state_s = ST_BUS;
                    end
                end
                default: begin
                    fsm_state_s = ST_PARK;
                    fsm_beat_s  = 4'd0;
                end
            endcase
        end else begin
            fsm_state_s = state_q;
        end
    end

    // Grant/pointer resolution: apply the picker result on re-arbitration.
    always_comb begin
        state_d    = fsm_state_s;
        beat_cnt_d = fsm_beat_s;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        if (rearb_s && pick_valid_s) begin
            state_d = ST_BUS;
            grant_d = pick_gnt_s;
            ptr_d   = onehot_to_idx(pick_gnt_s);
        end else if (rearb_s || (fsm_state_s == ST_PARK)) begin
            state_d = ST_PARK;
            grant_d = DEF_OH;
        end else begin
            grant_d = grant_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PARK;
            grant_q    <= DEF_OH;
            ptr_q      <= DEF_IDX;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Address-phase owner: follows the grant one accepted cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else if (hready_i) begin
            hmaster_q   <= grant_idx_s;
            hmastlock_q <= lock_i[grant_idx_s];
        end else begin
            hmaster_q   <= hmaster_q;
            hmastlock_q <= hmastlock_q;
        end
    end

    assign grant_o     = grant_q;
    assign hmaster_o   = hmaster_q;
    assign hmastlock_o = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed stimulus for ahb_arbiter (NUM_MST=4, DEF_MST=0, TIMEOUT=16).
// Each stimulus step queues the outputs expected after its clock edge; an
// independent monitor pops and compares them on the falling edge.
// ----------------------------------------------------------------------------
module tb_ahb_arbiter;
    import ahb_pkg::*;

`ifdef AHB_ARB_TIMEOUT_EN
    localparam bit         TO_EN    = 1'b1;
    localparam int         TO_STEPS = 16;
    localparam logic [3:0] OWN_OH   = 4'b1000;
    localparam logic [1:0] OWN_IDX  = 2'd3;
`else
    localparam bit         TO_EN    = 1'b0;
    localparam int         TO_STEPS = 100;
    localparam logic [3:0] OWN_OH   = 4'b0001;
    localparam logic [1:0] OWN_IDX  = 2'd0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic [1:0] htrans_i;
    logic [2:0] hburst_i;
    logic       hready_i;
    logic [3:0] grant_o;
    logic [1:0] hmaster_o;
    logic       hmastlock_o;

    typedef struct {
        int         due;
        logic [3:0] g;
        logic [1:0] hm;
        logic       hl;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    ahb_arbiter #(
        .NUM_MST (4),
        .DEF_MST (0),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .htrans_i    (htrans_i),
        .hburst_i    (hburst_i),
        .hready_i    (hready_i),
        .grant_o     (grant_o),
        .hmaster_o   (hmaster_o),
        .hmastlock_o (hmastlock_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that has become due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                total++;
                if (grant_o !== e.g || hmaster_o !== e.hm || hmastlock_o !== e.hl) begin
                    bad++;
                    $display("FAIL %s: got grant=%b hmaster=%0d hmastlock=%b, want grant=%b hmaster=%0d hmastlock=%b",
                             e.tag, grant_o, hmaster_o, hmastlock_o, e.g, e.hm, e.hl);
                end
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                        input logic [2:0] b, input logic rdy, input logic [3:0] eg,
                        input logic [1:0] em, input logic el, input string tag);
        exp_t e;
        req_i    = r;
        lock_i   = l;
        htrans_i = t;
        hburst_i = b;
        hready_i = rdy;
        e.due = cyc + 1;
        e.g   = eg;
        e.hm  = em;
        e.hl  = el;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation for the current cycle (checked at the next falling edge).
    task automatic chk_now(input logic [3:0] eg, input logic [1:0] em, input logic el,
                           input string tag);
        exp_t e;
        e.due = cyc;
        e.g   = eg;
        e.hm  = em;
        e.hl  = el;
        e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req_i    = 4'b0000;
        lock_i   = 4'b0000;
        htrans_i = HTRANS_IDLE;
        hburst_i = HBURST_SINGLE;
        hready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_now(4'b0001, 2'd0, 1'b0, "rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin: each owner drops its request after one single transfer.
        step(4'b1111, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, "rr_m1");
        step(4'b1101, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0, "rr_m2");
        step(4'b1011, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b1000, 2'd2, 1'b0, "rr_m3");
        step(4'b0111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0, "rr_m0");
        step(4'b1110, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, "rr_m1_again");

        // INCR4 by m2 with m3 waiting; 2 BUSY and 3 wait cycles inside.
        step(4'b0100, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0, "b4_own_m2");
        step(4'b1100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 1'b0, "b4_start");
        step(4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 4'b0100, 2'd2, 1'b0, "b4_wait1");
        step(4'b1100, 4'b0000, HTRANS_BUSY,   HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 1'b0, "b4_busy1");
        step(4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 1'b0, "b4_beat2");
        step(4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 4'b0100, 2'd2, 1'b0, "b4_wait2");
        step(4'b1100, 4'b0000, HTRANS_BUSY,   HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 1'b0, "b4_busy2");
        step(4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 4'b0100, 2'd2, 1'b0, "b4_wait3");
        step(4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0100, 2'd2, 1'b0, "b4_beat3");
        step(4'b1100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b1000, 2'd2, 1'b0, "b4_beat4_handover");
        step(4'b1000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b0, 4'b1000, 2'd2, 1'b0, "b4_hm_frozen");
        step(4'b1000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b1000, 2'd3, 1'b0, "b4_hm_m3");

        // Lock held by m1 for 10 cycles while m0 and m2 request.
        step(4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd3, 1'b0, "lk_own_m1");
        for (int k = 0; k < 10; k++) begin
            step(4'b0111, 4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 4'b0010, 2'd1, 1'b1, "lk_hold");
        end
        step(4'b0101, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0, "lk_release_m2");
        step(4'b0101, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0, "lk_m2_hm");

        // Early termination of INCR8 by m0 after 3 beats; m1 waiting.
        step(4'b0001, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0, "et_own_m0");
        step(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8,  1'b1, 4'b0001, 2'd0, 1'b0, "et_start");
        step(4'b0011, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, 4'b0001, 2'd0, 1'b0, "et_beat2");
        step(4'b0010, 4'b0000, HTRANS_SEQ,    HBURST_INCR8,  1'b1, 4'b0001, 2'd0, 1'b0, "et_beat3_noreq");
        step(4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_INCR8,  1'b1, 4'b0010, 2'd0, 1'b0, "et_idle_m1");

        // Lock and burst start together: count survives the unlock.
        step(4'b0110, 4'b0010, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b1, "lb_start");
        step(4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, "lb_unlock_midburst");
        step(4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, "lb_beat3");
        step(4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0100, 2'd1, 1'b0, "lb_beat4_m2");

        // Lone requester keeps the grant.
        step(4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0, "sm_hold1");
        step(4'b0100, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0, "sm_hold2");

        // Idle owner m0 keeps requesting while m3 waits.
        step(4'b0001, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0, "to_own_m0");
        for (int k = 1; k <= TO_STEPS; k++) begin
            step(4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1,
                 (TO_EN && k == 16) ? 4'b1000 : 4'b0001, 2'd0, 1'b0, "to_idle");
        end

        // Reset in the middle of a burst.
        step(OWN_OH,  4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, OWN_OH,  OWN_IDX, 1'b0, "mr_burst_start");
        step(OWN_OH,  4'b0000, HTRANS_SEQ,    HBURST_INCR16, 1'b1, OWN_OH,  OWN_IDX, 1'b0, "mr_beat2");
        rst = 1'b1;
        chk_now(4'b0001, 2'd0, 1'b0, "rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b0000, 4'b0000, HTRANS_SEQ,    HBURST_INCR16, 1'b1, 4'b0001, 2'd0, 1'b0, "mr_park");
        step(4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR16, 1'b1, 4'b0100, 2'd0, 1'b0, "mr_regrant_m2");
        step(4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0, "mr_back_to_park");

        repeat (4) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: pending=%0d want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
